// File: rtl/accelerator_pkg.sv
// Shared types and constants for the accelerator Avalon-MM master.
package accelerator_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        NEXT    = 3'd4,
        FINISH  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        MODE_COPY  = 2'b00,
        MODE_INV   = 2'b01,
        MODE_BSWAP = 2'b10,
        MODE_ZERO  = 2'b11
    } mode_e;

endpackage

// File: rtl/accelerator_word_transform.sv
// Per-word data transform applied between the read return and the write.
module accelerator_word_transform
    import accelerator_pkg::*;
(
    input  logic [1:0]  mode,
    input  logic [31:0] word_in,
    output logic [31:0] word_c
);

    always_comb begin
        word_c = word_in;
        case (mode_e'(mode))
            MODE_COPY:  word_c = word_in;
            MODE_INV:   word_c = ~word_in;
            MODE_BSWAP: word_c = {word_in[7:0], word_in[15:8], word_in[23:16], word_in[31:24]};
            MODE_ZERO:  word_c = 32'd0;
            default:    word_c = word_in;
        endcase
    end

endmodule

// File: rtl/accelerator_master.sv
// Avalon-MM master: on a START rising edge, reads LENGTH words from SRC,
// transforms each one and writes it to DST, then pulses DONE.
module accelerator_master
    import accelerator_pkg::*;
#(
    parameter int unsigned AVM_DATA_WIDTH    = 32,
    parameter int unsigned AVM_ADDRESS_WIDTH = 32,
    parameter int unsigned LEN_WIDTH         = 16
) (
    input  logic                         CSI_CLOCK_CLK,
    input  logic                         CSI_CLOCK_RESET,
    input  logic                         START,
    output logic                         DONE,
    output logic                         BUSY,
    input  logic [31:0]                  CONTROL_REG,
    input  logic [31:0]                  SRC_ADDR,
    input  logic [31:0]                  DST_ADDR,
    input  logic [31:0]                  LENGTH,
    output logic [AVM_ADDRESS_WIDTH-1:0] AVM_AVALONMASTER_ADDRESS,
    output logic                         AVM_AVALONMASTER_READ,
    output logic                         AVM_AVALONMASTER_WRITE,
    input  logic                         AVM_AVALONMASTER_WAITREQUEST,
    input  logic [AVM_DATA_WIDTH-1:0]    AVM_AVALONMASTER_READDATA,
    input  logic                         AVM_AVALONMASTER_READDATAVALID,
    output logic [AVM_DATA_WIDTH-1:0]    AVM_AVALONMASTER_WRITEDATA
);

    localparam int unsigned AW = AVM_ADDRESS_WIDTH;
    localparam int unsigned DW = AVM_DATA_WIDTH;
    localparam int unsigned LW = LEN_WIDTH;

    state_e          state_q,     state_d;
    logic            start_dly_q, start_dly_d;
    logic [AW-1:0]   src_ptr_q,   src_ptr_d;
    logic [AW-1:0]   dst_ptr_q,   dst_ptr_d;
    logic [LW-1:0]   len_q,       len_d;
    logic [LW-1:0]   cnt_q,       cnt_d;
    logic [1:0]      mode_q,      mode_d;
    logic [AW-1:0]   address_q,   address_d;
    logic            read_q,      read_d;
    logic            write_q,     write_d;
    logic [DW-1:0]   wdata_q,     wdata_d;
    logic            done_q,      done_d;
    logic            busy_q,      busy_d;
    logic            accept_c;
    logic [31:0]     xform_word_c;

    // Register bits that carry no meaning for this stage
    logic unused_bits_c;
    assign unused_bits_c = ^{CONTROL_REG[31:3], CONTROL_REG[0], LENGTH[31:LW]};

    accelerator_word_transform u_xform (
        .mode    (mode_q),
        .word_in (AVM_AVALONMASTER_READDATA),
        .word_c  (xform_word_c)
    );

    always_comb begin
        state_d     = state_q;
        start_dly_d = START;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        wdata_d     = wdata_q;
        done_d      = 1'b0;
        accept_c    = START & ~start_dly_q & (state_q == IDLE);

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    src_ptr_d = AW'(SRC_ADDR);
                    dst_ptr_d = AW'(DST_ADDR);
                    len_d     = LENGTH[LW-1:0];
                    mode_d    = CONTROL_REG[2:1];
                    cnt_d     = '0;
                    state_d   = (LENGTH[LW-1:0] == '0) ? FINISH : RD_REQ;
                end
            end
            RD_REQ: begin
                if (!AVM_AVALONMASTER_WAITREQUEST) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (AVM_AVALONMASTER_READDATAVALID) begin
                    wdata_d = DW'(xform_word_c);
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                if (!AVM_AVALONMASTER_WAITREQUEST) state_d = NEXT;
            end
            NEXT: begin
                src_ptr_d = src_ptr_q + AW'(WORD_BYTES);
                dst_ptr_d = dst_ptr_q + AW'(WORD_BYTES);
                cnt_d     = cnt_q + LW'(1);
                state_d   = (cnt_d == len_q) ? FINISH : RD_REQ;
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Bus outputs follow the upcoming state so they are valid for that whole cycle
        read_d    = (state_d == RD_REQ);
        write_d   = (state_d == WR_REQ);
        address_d = address_q;
        if (read_d) begin
            address_d = {src_ptr_d[AW-1:2], 2'b00};
        end else if (write_d) begin
            address_d = {dst_ptr_d[AW-1:2], 2'b00};
        end
        busy_d = (state_d != IDLE) | done_d;
    end

    always_ff @(posedge CSI_CLOCK_CLK or posedge CSI_CLOCK_RESET) begin
        if (CSI_CLOCK_RESET) begin
            state_q     <= IDLE;
            start_dly_q <= 1'b0;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            mode_q      <= 2'b00;
            address_q   <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_dly_q <= start_dly_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            address_q   <= address_d;
            read_q      <= read_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign DONE                       = done_q;
    assign BUSY                       = busy_q;
    assign AVM_AVALONMASTER_ADDRESS   = address_q;
    assign AVM_AVALONMASTER_READ      = read_q;
    assign AVM_AVALONMASTER_WRITE     = write_q;
    assign AVM_AVALONMASTER_WRITEDATA = wdata_q;

endmodule
